instruction_fetch_unit: RTL and testbench

- Upstream neighbour of the instruction decoder in the accumulator CPU.
- Owns the program counter and drives the synchronous program memory. It holds each fetched word in an instruction register and presents opcode/operand to the decoder with a one-cycle valid strobe.
- Consumes the decoder's PC-enable to advance or stop. Also provides halt detection, single-step mode and an executed-instruction counter.

---
 rtl/instruction_fetch_unit.sv | 123 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads the synchronous program memory and
// hands each instruction to the decoder with a one-cycle valid strobe.
`timescale 1ns/1ps
module instruction_fetch_unit #(
    parameter int unsigned NB_ADDR        = 11,
    parameter int unsigned NB_INSTRUCTION = 16,
    parameter int unsigned NB_OPCODE      = 5,
    parameter int unsigned NB_OPERAND     = 11,
    parameter int unsigned NB_COUNT       = 32
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_enb_pc,
    input  logic                      i_step_mode,
    input  logic                      i_step,
    input  logic [NB_INSTRUCTION-1:0] i_prog_data,
    output logic [NB_ADDR-1:0]        o_prog_addr,
    output logic                      o_prog_rd_enb,
    output logic [NB_OPCODE-1:0]      o_opcode,
    output logic [NB_OPERAND-1:0]     o_operand,
    output logic                      o_valid,
    output logic [NB_ADDR-1:0]        o_pc,
    output logic                      o_halted,
    output logic                      o_pc_overflow,
    output logic [NB_COUNT-1:0]       o_instr_count
);

    localparam logic [NB_ADDR-1:0]  PC_MAX    = '1;
    localparam logic [NB_COUNT-1:0] COUNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_EXEC,
        S_STEP_WAIT,
        S_HALTED
    } state_t;

    state_t                    state;
    logic [NB_ADDR-1:0]        pc;
    logic [NB_INSTRUCTION-1:0] ir;
    logic                      step_q;
    logic                      step_edge;

    assign step_edge = i_step & ~step_q;

    // Strobes are registered alongside the state they belong to, so they
    // track the current state exactly without a combinational decode.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state         <= S_IDLE;
            pc            <= '0;
            ir            <= '0;
            step_q        <= 1'b0;
            o_instr_count <= '0;
            o_pc_overflow <= 1'b0;
            o_valid       <= 1'b0;
            o_prog_rd_enb <= 1'b0;
            o_halted      <= 1'b0;
        end else begin
            step_q        <= i_step;
            o_valid       <= 1'b0;
            o_prog_rd_enb <= 1'b0;
            o_halted      <= 1'b0;
            case (state)
                S_IDLE: begin
                    state         <= S_FETCH;
                    o_prog_rd_enb <= 1'b1;
                end
                S_FETCH: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    ir      <= i_prog_data;
                    state   <= S_EXEC;
                    o_valid <= 1'b1;
                end
                S_EXEC: begin
                    if (o_instr_count != COUNT_MAX) begin
                        o_instr_count <= o_instr_count + NB_COUNT'(1);
                    end
                    if (!i_enb_pc) begin
                        state    <= S_HALTED;
                        o_halted <= 1'b1;
                    end else if (pc == PC_MAX) begin
                        // No wrap: running off the end of memory stops the CPU.
                        o_pc_overflow <= 1'b1;
                        state         <= S_HALTED;
                        o_halted      <= 1'b1;
                    end else begin
                        pc <= pc + NB_ADDR'(1);
                        if (i_step_mode) begin
                            state <= S_STEP_WAIT;
                        end else begin
                            state         <= S_FETCH;
                            o_prog_rd_enb <= 1'b1;
                        end
                    end
                end
                S_STEP_WAIT: begin
                    // Step edges seen in other states are simply dropped.
                    if (step_edge || !i_step_mode) begin
                        state         <= S_FETCH;
                        o_prog_rd_enb <= 1'b1;
                    end
                end
                S_HALTED: begin
                    o_halted <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_prog_addr = pc;
    assign o_pc        = pc;
    assign o_opcode    = ir[NB_INSTRUCTION-1 -: NB_OPCODE];
    assign o_operand   = ir[NB_OPERAND-1:0];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: cycle table for the reference program,
// hand-written corner sequences and randomized programs against a program-level model.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, step_mode, step;
    logic [15:0] mem [0:2047];

    logic [15:0] prog_data, s_prog_data;
    logic [10:0] prog_addr, pc, s_prog_addr, s_pc;
    logic        rd_enb, valid, halted, overflow, enb_pc;
    logic        s_rd_enb, s_valid, s_halted, s_overflow, s_enb_pc;
    logic [4:0]  opcode, s_opcode;
    logic [10:0] operand, s_operand;
    logic [31:0] count;
    logic [1:0]  s_count;

    instruction_fetch_unit dut (
        .i_clock(clk), .i_reset(rst_n), .i_enb_pc(enb_pc), .i_step_mode(step_mode),
        .i_step(step), .i_prog_data(prog_data), .o_prog_addr(prog_addr),
        .o_prog_rd_enb(rd_enb), .o_opcode(opcode), .o_operand(operand), .o_valid(valid),
        .o_pc(pc), .o_halted(halted), .o_pc_overflow(overflow), .o_instr_count(count)
    );

    instruction_fetch_unit #(.NB_COUNT(2)) dut_sat (
        .i_clock(clk), .i_reset(rst_n), .i_enb_pc(s_enb_pc), .i_step_mode(step_mode),
        .i_step(step), .i_prog_data(s_prog_data), .o_prog_addr(s_prog_addr),
        .o_prog_rd_enb(s_rd_enb), .o_opcode(s_opcode), .o_operand(s_operand), .o_valid(s_valid),
        .o_pc(s_pc), .o_halted(s_halted), .o_pc_overflow(s_overflow), .o_instr_count(s_count)
    );

    // Synchronous program memories and a decoder that halts on opcode 0.
    always @(posedge clk) if (rd_enb) prog_data <= mem[prog_addr];
    always @(posedge clk) if (s_rd_enb) s_prog_data <= mem[s_prog_addr];
    assign enb_pc   = (opcode != 5'd0);
    assign s_enb_pc = (s_opcode != 5'd0);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_basic();
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
        mem[0] = 16'h1805;
        mem[1] = 16'h2803;
        mem[2] = 16'h0000;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " valid"},    32'(valid),    32'd0);
        check({tag, " rd_enb"},   32'(rd_enb),   32'd0);
        check({tag, " opcode"},   32'(opcode),   32'd0);
        check({tag, " operand"},  32'(operand),  32'd0);
        check({tag, " pc"},       32'(pc),       32'd0);
        check({tag, " halted"},   32'(halted),   32'd0);
        check({tag, " overflow"}, 32'(overflow), 32'd0);
        check({tag, " count"},    count,         32'd0);
    endtask

    // Leaves the bench at cycle 0: just after the negedge where reset is released.
    task automatic do_reset();
        rst_n = 1'b0;
        step  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        valid;
        logic        rd;
        logic        halted;
        logic [4:0]  opc;
        logic [10:0] opr;
        logic [10:0] pc;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int nv, first_k, idx, last_v, p, n0;
        bit done;

        rst_n = 1'b0; step = 1'b0; step_mode = 1'b0;

        // Free-run reference program, expected state cycle by cycle after release.
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 5'd0, 11'd0, 11'd0, 32'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 5'd0, 11'd0, 11'd0, 32'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 5'd0, 11'd0, 11'd0, 32'd0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 5'd3, 11'd5, 11'd0, 32'd0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 5'd3, 11'd5, 11'd1, 32'd1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 5'd3, 11'd5, 11'd1, 32'd1};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 5'd5, 11'd3, 11'd1, 32'd1};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 5'd5, 11'd3, 11'd2, 32'd2};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 5'd5, 11'd3, 11'd2, 32'd2};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 5'd0, 11'd0, 11'd2, 32'd2};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 5'd0, 11'd0, 11'd2, 32'd3};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 5'd0, 11'd0, 11'd2, 32'd3};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 5'd0, 11'd0, 11'd2, 32'd3};

        load_basic();
        do_reset();
        for (int c = 0; c < 13; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            check($sformatf("c%0d valid", c),   32'(valid),   32'(tbl[c].valid));
            check($sformatf("c%0d rd_enb", c),  32'(rd_enb),  32'(tbl[c].rd));
            check($sformatf("c%0d halted", c),  32'(halted),  32'(tbl[c].halted));
            check($sformatf("c%0d opcode", c),  32'(opcode),  32'(tbl[c].opc));
            check($sformatf("c%0d operand", c), 32'(operand), 32'(tbl[c].opr));
            check($sformatf("c%0d pc", c),      32'(pc),      32'(tbl[c].pc));
            check($sformatf("c%0d count", c),   count,        tbl[c].cnt);
        end

        // Step mode: one instruction, then wait indefinitely without a step.
        step_mode = 1'b1;
        do_reset();
        nv = 0;
        for (int c = 1; c <= 24; c++) begin
            @(posedge clk);
            #1;
            if (valid) nv++;
        end
        check("step first instr", 32'(nv), 32'd1);
        check("step wait pc", 32'(pc), 32'd1);
        check("step wait valid", 32'(valid), 32'd0);
        // One pulse -> exactly one more instruction, valid two edges after the sampling edge.
        @(negedge clk) step = 1'b1;
        @(negedge clk) step = 1'b0;
        nv = 0; first_k = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                nv++;
                if (first_k == 0) first_k = k;
                check("step pulse opcode", 32'(opcode), 32'd5);
            end
        end
        check("step pulse count", 32'(nv), 32'd1);
        check("step pulse latency", 32'(first_k), 32'd2);
        check("step pulse pc", 32'(pc), 32'd2);
        // A held step level is only one edge.
        @(negedge clk) step = 1'b1;
        nv = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (valid) nv++;
        end
        @(negedge clk) step = 1'b0;
        check("step held count", 32'(nv), 32'd1);
        check("step held halted", 32'(halted), 32'd1);
        check("step held instr", count, 32'd3);

        // Releasing step mode while waiting resumes the fetch on the next edge.
        step_mode = 1'b1;
        do_reset();
        repeat (8) @(posedge clk);
        @(negedge clk) step_mode = 1'b0;
        @(posedge clk);
        #1;
        check("release rd_enb", 32'(rd_enb), 32'd1);
        check("release addr", 32'(prog_addr), 32'd1);
        done = 1'b0;
        for (int k = 0; k < 30 && !done; k++) begin
            @(posedge clk);
            #1;
            done = halted;
        end
        check("release halted", 32'(halted), 32'd1);
        check("release count", count, 32'd3);
        check("release pc", 32'(pc), 32'd2);

        // Reset during LOAD, then during HALTED.
        load_basic();
        do_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("rst load");
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst load restart valid", 32'(valid), 32'd1);
        check("rst load restart opcode", 32'(opcode), 32'd3);
        check("rst load restart count", count, 32'd0);
        repeat (10) @(posedge clk);
        #1;
        check("pre rst halted", 32'(halted), 32'd1);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("rst halted");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst halted restart addr0", 32'(rd_enb), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("rst halted restart valid", 32'(valid), 32'd1);
        check("rst halted restart operand", 32'(operand), 32'd5);

        // PC overflow on an all-ADDI memory; narrow-counter instance rides along.
        for (int i = 0; i < 2048; i++) mem[i] = 16'h2801;
        step_mode = 1'b0;
        do_reset();
        n0 = 0; done = 1'b0;
        for (int c = 1; c <= 7000 && !done; c++) begin
            @(posedge clk);
            #1;
            if (rd_enb && prog_addr == 11'd0) n0++;
            if (c == 7)  check("sat count at 2", 32'(s_count), 32'd2);
            if (c == 16) check("sat count after 5", 32'(s_count), 32'd3);
            done = halted;
        end
        check("ovf halted in budget", 32'(done), 32'd1);
        repeat (5) begin
            @(posedge clk);
            #1;
            if (rd_enb) n0++;
        end
        check("ovf flag", 32'(overflow), 32'd1);
        check("ovf halted", 32'(halted), 32'd1);
        check("ovf pc", 32'(pc), 32'd2047);
        check("ovf count", count, 32'd2048);
        check("ovf no wrap fetch", 32'(n0), 32'd1);
        check("sat count final", 32'(s_count), 32'd3);

        // Random programs with random step activity, checked against the program order.
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 2048; i++) mem[i] = {5'($urandom_range(31, 1)), 11'($urandom)};
            p = int'($urandom_range(40, 0));
            mem[p] = {5'd0, 11'($urandom)};
            step_mode = 1'($urandom_range(1, 0));
            do_reset();
            idx = 0; last_v = -100; done = 1'b0;
            for (int c = 1; c <= 3000 && !done; c++) begin
                @(negedge clk);
                if ($urandom_range(7, 0) == 0) step_mode = ~step_mode;
                step = 1'($urandom_range(1, 0));
                @(posedge clk);
                #1;
                if (rd_enb) check($sformatf("rnd%0d fetch addr", it), 32'(prog_addr), 32'(idx));
                if (valid) begin
                    check($sformatf("rnd%0d i%0d opcode", it, idx), 32'(opcode), 32'(mem[idx][15:11]));
                    check($sformatf("rnd%0d i%0d operand", it, idx), 32'(operand), 32'(mem[idx][10:0]));
                    check($sformatf("rnd%0d i%0d count", it, idx), count, 32'(idx));
                    check($sformatf("rnd%0d i%0d spacing", it, idx), 32'(c - last_v >= 3), 32'd1);
                    last_v = c;
                    idx++;
                end
                done = halted;
            end
            step = 1'b0;
            check($sformatf("rnd%0d halted", it), 32'(halted), 32'd1);
            check($sformatf("rnd%0d executed", it), 32'(idx), 32'(p + 1));
            check($sformatf("rnd%0d pc", it), 32'(pc), 32'(p));
            check($sformatf("rnd%0d count", it), count, 32'(p + 1));
            check($sformatf("rnd%0d overflow", it), 32'(overflow), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
